// File: rtl/clip_pkg.sv
// Shared types and command-bit positions for the clip record/playback controller.
package clip_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REC,
    PLAY
  } state_t;

  localparam int CMD_SRST = 4;
  localparam int CMD_REC  = 3;
  localparam int CMD_PLAY = 2;
  localparam int CMD_WSEL = 1;
  localparam int CMD_RSEL = 0;

endpackage

// File: rtl/clip_controller_if.sv
// Two-clip audio memory strobe/address bus.
interface clip_controller_if #(
  parameter int ADDR_W = 14
);

  logic [ADDR_W:0] mem_addr;
  logic            mem_we;
  logic            mem_re;

  modport master (
    output mem_addr,
    output mem_we,
    output mem_re
  );

  modport slave (
    input mem_addr,
    input mem_we,
    input mem_re
  );

endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector; history resets to all-ones so held inputs are not presses.
module edge_detect #(
  parameter int W = 5
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);

  logic [W-1:0] d_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) d_q <= '1;
    else          d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/clip_controller.sv
// Record/playback FSM for a two-clip sample memory.
// Build option: define LOOP_PLAY_EN for looping playback.
module clip_controller
  import clip_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [4:0]          sync_cmd,
  input  logic                sample_tick,
  clip_controller_if.master   mem,
  output logic                recording,
  output logic                playing,
  output logic                done
);

  localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [4:0]        rise;
  state_t            state;
  logic              wsel;
  logic              rsel;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   len [2];
  logic [ADDR_W:0]   addr;
  logic              we;
  logic              re;
  logic [ADDR_W:0]   idx_ext;
  logic [ADDR_W:0]   last_rd;
  logic              has_clip;

  edge_detect #(.W(5)) u_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (sync_cmd),
    .rise    (rise)
  );

  assign idx_ext  = {1'b0, idx};
  assign last_rd  = len[rsel] - ONE;
  assign has_clip = |len[sync_cmd[CMD_RSEL]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wsel      <= 1'b0;
      rsel      <= 1'b0;
      idx       <= '0;
      len[0]    <= '0;
      len[1]    <= '0;
      addr      <= '0;
      we        <= 1'b0;
      re        <= 1'b0;
      recording <= 1'b0;
      playing   <= 1'b0;
      done      <= 1'b0;
    end else begin
      we   <= 1'b0;
      re   <= 1'b0;
      done <= 1'b0;
      if (sync_cmd[CMD_SRST]) begin
        state     <= IDLE;
        recording <= 1'b0;
        playing   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (rise[CMD_REC]) begin
              state     <= REC;
              wsel      <= sync_cmd[CMD_WSEL];
              idx       <= '0;
              recording <= 1'b1;
            end else if (rise[CMD_PLAY] && has_clip) begin
              state   <= PLAY;
              rsel    <= sync_cmd[CMD_RSEL];
              idx     <= '0;
              playing <= 1'b1;
            end
          end
          REC: begin
            if (rise[CMD_REC]) begin
              len[wsel] <= idx_ext;
              done      <= 1'b1;
              state     <= IDLE;
              recording <= 1'b0;
            end else if (sample_tick) begin
              we   <= 1'b1;
              addr <= {wsel, idx};
              idx  <= idx + 1'b1;
              // Last slot written: clip is full, stop on the wrap.
              if (&idx) begin
                len[wsel] <= FULL;
                done      <= 1'b1;
                state     <= IDLE;
                recording <= 1'b0;
              end
            end
          end
          PLAY: begin
            if (rise[CMD_PLAY]) begin
              done    <= 1'b1;
              state   <= IDLE;
              playing <= 1'b0;
            end else if (sample_tick) begin
              re   <= 1'b1;
              addr <= {rsel, idx};
              idx  <= idx + 1'b1;
              if (idx_ext == last_rd) begin
`ifdef LOOP_PLAY_EN
                idx <= '0;
`else
                done    <= 1'b1;
                state   <= IDLE;
                playing <= 1'b0;
`endif
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign mem.mem_addr = addr;
  assign mem.mem_we   = we;
  assign mem.mem_re   = re;

endmodule

// File: tb/tb_clip_controller.sv
// Randomized directed bench for clip_controller with a transaction-level model.
module tb_clip_controller;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic       clock;
  logic       reset_n;
  logic [4:0] sync_cmd;
  logic       sample_tick;
  logic       recording;
  logic       playing;
  logic       done;

  clip_controller_if #(.ADDR_W(AW)) bus ();

  clip_controller #(.ADDR_W(AW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sync_cmd    (sync_cmd),
    .sample_tick (sample_tick),
    .mem         (bus),
    .recording   (recording),
    .playing     (playing),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int dcnt  = 0;
  bit both_seen = 0;
  int wq [$];
  int rq [$];
  int len_m [2];

  always @(negedge clock) begin
    if (bus.mem_we) wq.push_back(int'(bus.mem_addr));
    if (bus.mem_re) rq.push_back(int'(bus.mem_addr));
    if (done) dcnt++;
    if (bus.mem_we && bus.mem_re) both_seen = 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mon();
    wq.delete();
    rq.delete();
    dcnt = 0;
  endtask

  task automatic press(input logic [4:0] b, input logic [4:0] lv,
                       input bit tk);
    sync_cmd    = lv;
    sample_tick = 1'b0;
    step();
    sync_cmd    = lv | b;
    sample_tick = tk;
    step();
    sync_cmd    = lv;
    sample_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) step();
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
    end
    step();
  endtask

  task automatic rec(input bit sel, input int nt);
    logic [4:0] lv;
    int nw;
    bit full;
    lv = {3'b000, sel, 1'b0};
    clear_mon();
    press(5'b01000, lv, 1'b0);
    chk("rec_enter", recording, 1);
    ticks(nt);
    full = (nt >= DEPTH);
    nw   = full ? DEPTH : nt;
    chk("rec_active", recording, !full);
    if (!full) begin
      press(5'b01000, lv, 1'($urandom_range(0, 1)));
      chk("rec_stop", recording, 0);
    end
    step();
    step();
    chk("rec_nwrites", wq.size(), nw);
    for (int i = 0; i < wq.size() && i < nw; i++)
      chk("rec_addr", wq[i], (int'(sel) << AW) | i);
    chk("rec_done", dcnt, 1);
    len_m[sel] = nw;
  endtask

  task automatic play(input bit sel, input int nt);
    logic [4:0] lv;
    int nr;
    int ln;
    bit still;
    lv = {4'b0000, sel};
    ln = len_m[sel];
    clear_mon();
    press(5'b00100, lv, 1'b0);
    chk("play_enter", playing, ln != 0);
    ticks(nt);
    if (ln == 0) begin
      step();
      chk("empty_reads", rq.size(), 0);
      chk("empty_done", dcnt, 0);
      chk("empty_idle", playing, 0);
    end else begin
`ifdef LOOP_PLAY_EN
      nr    = nt;
      still = 1;
`else
      nr    = (nt < ln) ? nt : ln;
      still = (nt < ln);
`endif
      chk("play_active", playing, still);
      if (still) begin
        press(5'b00100, lv, 1'($urandom_range(0, 1)));
        chk("play_stop", playing, 0);
      end
      step();
      step();
      chk("play_nreads", rq.size(), nr);
      for (int i = 0; i < rq.size() && i < nr; i++)
        chk("play_addr", rq[i], (int'(sel) << AW) | (i % ln));
      chk("play_done", dcnt, 1);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    sync_cmd    = 5'b01000;
    sample_tick = 1'b0;
    len_m[0]    = 0;
    len_m[1]    = 0;
    repeat (3) step();
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_re", bus.mem_re, 0);
    chk("rst_rec", recording, 0);
    chk("rst_play", playing, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    repeat (3) step();
    chk("held_no_rec", recording, 0);

    // Fresh press, then an empty recording of clip 0.
    clear_mon();
    press(5'b01000, 5'b00000, 1'b0);
    chk("press_rec", recording, 1);
    press(5'b01000, 5'b00000, 1'b0);
    chk("empty_rec_stop", recording, 0);
    step();
    chk("empty_rec_done", dcnt, 1);
    chk("empty_rec_w", wq.size(), 0);

    rec(1'b1, 5);
    play(1'b1, 7);
    play(1'b0, 3);
    rec(1'b0, 10);
    play(1'b0, 8);

    // Simultaneous rises, ignored play press, then soft reset.
    clear_mon();
    press(5'b01100, 5'b00000, 1'b0);
    chk("both_rec", recording, 1);
    chk("both_play", playing, 0);
    ticks(2);
    press(5'b00100, 5'b00000, 1'b0);
    chk("rec_ign_play", recording, 1);
    chk("rec_ign_play2", playing, 0);
    sync_cmd    = 5'b10000;
    sample_tick = 1'b1;
    step();
    chk("srst_rec", recording, 0);
    chk("srst_we", bus.mem_we, 0);
    chk("srst_done", done, 0);
    sync_cmd    = 5'b00000;
    sample_tick = 1'b0;
    step();
    step();
    chk("srst_nw", wq.size(), 2);
    chk("srst_dcnt", dcnt, 0);
    play(1'b0, 9);

    for (int k = 0; k < 6; k++) begin
      rec(1'($urandom_range(0, 1)), $urandom_range(0, 10));
      play(1'($urandom_range(0, 1)), $urandom_range(0, 10));
    end

    // Asynchronous reset mid-recording loses both lengths.
    rec(1'b1, 4);
    clear_mon();
    press(5'b01000, 5'b00010, 1'b0);
    ticks(2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_rec", recording, 0);
    chk("arst_addr", bus.mem_addr, 0);
    chk("arst_we", bus.mem_we, 0);
    step();
    reset_n  = 1'b1;
    sync_cmd = 5'b00000;
    len_m[0] = 0;
    len_m[1] = 0;
    step();
    play(1'b1, 3);

    chk("we_re_excl", both_seen, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
